// File: rtl/mult4_seq_ctrl.sv
// mult4_seq_ctrl
// Unsigned 4x4 -> 8-bit multiplier sequencer. One external combinational
// 2x2 -> 4-bit core is reused over four cycles. Each cycle adds one shifted
// partial product (lo*lo, lo*hi, hi*lo, hi*hi) into an 8-bit accumulator.
// The finished product is offered on a valid/ready output.
//
// Parameters
//   ZERO_SKIP : 1 -> an operand pair with A==0 or B==0 skips the core
//               steps and completes with P=0
//   CNT_W     : width of the completed-operation counter
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand pair valid
//   in_ready   operands accepted (IDLE only)
//   A, B       4-bit operands, latched on accept
//   out_valid  P holds a completed product
//   out_ready  consumer takes P
//   P          registered 8-bit product
//   mul_a/b    operand halves driven to the shared 2x2 core
//   mul_p      product returned by the core
//   busy       RUN or DONE
//   ops_done   output handshake count, wraps modulo 2^CNT_W
//
// state | meaning
// IDLE  | waiting for an operand pair
// RUN   | one partial product per cycle, step 0..3
// DONE  | holding P until the consumer takes it
module mult4_seq_ctrl #(
    parameter bit ZERO_SKIP = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       A,
    input  logic [3:0]       B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       P,
    output logic [1:0]       mul_a,
    output logic [1:0]       mul_b,
    input  logic [3:0]       mul_p,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       a_q, a_d;
    logic [3:0]       b_q, b_d;
    logic [7:0]       acc_q, acc_d;
    logic [1:0]       step_q, step_d;
    logic [7:0]       p_q, p_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] ops_q, ops_d;

    logic [1:0]       sel_a, sel_b;
    logic [2:0]       shift;
    logic [7:0]       pp;
    logic [7:0]       acc_sum;

    // Operand halves and weight for the current step. Selection comes from
    // registers only, so the core input is stable for the whole cycle.
    always_comb begin
        sel_a = 2'b00;
        sel_b = 2'b00;
        shift = 3'd0;
        case (step_q)
            2'd0: begin sel_a = a_q[1:0]; sel_b = b_q[1:0]; shift = 3'd0; end
            2'd1: begin sel_a = a_q[1:0]; sel_b = b_q[3:2]; shift = 3'd2; end
            2'd2: begin sel_a = a_q[3:2]; sel_b = b_q[1:0]; shift = 3'd2; end
            default: begin sel_a = a_q[3:2]; sel_b = b_q[3:2]; shift = 3'd4; end
        endcase
    end

    // Largest possible sum is 15*15 = 225, so 8 bits never overflow.
    assign pp      = {4'b0000, mul_p} << shift;
    assign acc_sum = acc_q + pp;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        step_d      = step_q;
        p_d         = p_q;
        out_valid_d = out_valid_q;
        ops_d       = ops_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d    = A;
                    b_d    = B;
                    acc_d  = 8'd0;
                    step_d = 2'd0;
                    if (ZERO_SKIP && ((A == 4'd0) || (B == 4'd0))) begin
                        p_d     = 8'd0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                acc_d  = acc_sum;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    p_d         = acc_sum;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                // A zero-skipped pair arrives here without out_valid. It
                // raises one cycle after the accept.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    ops_d       = ops_q + 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= 4'd0;
            b_q         <= 4'd0;
            acc_q       <= 8'd0;
            step_q      <= 2'd0;
            p_q         <= 8'd0;
            out_valid_q <= 1'b0;
            ops_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            step_q      <= step_d;
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
            ops_q       <= ops_d;
        end
    end

    // rst gating holds the status and core outputs quiet while reset is
    // asserted, including the cycles after the state register has already
    // cleared.
    assign in_ready  = !rst && (state_q == S_IDLE);
    assign busy      = !rst && ((state_q == S_RUN) || (state_q == S_DONE));
    assign mul_a     = (!rst && (state_q == S_RUN)) ? sel_a : 2'b00;
    assign mul_b     = (!rst && (state_q == S_RUN)) ? sel_b : 2'b00;
    assign out_valid = out_valid_q;
    assign P         = p_q;
    assign ops_done  = ops_q;

endmodule

// File: doc/mult4_seq_ctrl.md
# mult4_seq_ctrl

Sequencing controller that computes an unsigned 4x4 -> 8-bit product by time-multiplexing one shared, external, combinational 2x2 -> 4-bit multiplier core over four cycles. It accumulates the four shifted partial products (lo*lo, lo*hi, hi*lo, hi*hi) and presents the result through a valid/ready handshake. It is the area-reduced alternative to the fully parallel four-core 4-bit multiplier. The core under test plugs in unmodified through the mul_* ports.

## Interface
Parameters:
- ZERO_SKIP, default 0: when 1, an operand pair with A==0 or B==0 bypasses the four core steps and completes with P=0.
- CNT_W, default 16: width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept operands; high only in IDLE.
- A  in  4  multiplicand; sampled on accept.
- B  in  4  multiplier; sampled on accept.
- out_valid  out  1  P holds a completed product.
- out_ready  in  1  consumer accepts P.
- P  out  8  product, registered.
- mul_a  out  2  operand half driven to the shared 2x2 core.
- mul_b  out  2  operand half driven to the shared 2x2 core.
- mul_p  in  4  combinational product returned by the core.
- busy  out  1  high in RUN or DONE.
- ops_done  out  CNT_W  count of output handshakes; wraps modulo 2^CNT_W.

## Operation
- States: IDLE, RUN, DONE.
- Accept: an accept occurs when in_valid && in_ready at a clock edge. On accept, latch A and B into a_q and b_q, clear acc, set step=0, and go to RUN.
- ZERO_SKIP=1 with A==0 or B==0 at accept: go directly to DONE with P=0. Skip RUN entirely.
- RUN step schedule, as (mul_a, mul_b, shift):
  - step 0: (a_q[1:0], b_q[1:0], shift 0)
  - step 1: (a_q[1:0], b_q[3:2], shift 2)
  - step 2: (a_q[3:2], b_q[1:0], shift 2)
  - step 3: (a_q[3:2], b_q[3:2], shift 4)
- Each RUN cycle: acc <= acc + ({4'b0, mul_p} << shift), with the add done at 8 bits. The maximum sum is 225, so no overflow is possible. step increments by 1 per cycle.
- At step 3, the final sum is written to P, out_valid is set, and the state moves to DONE.
- DONE: hold P and out_valid stable until out_ready.
  - On out_valid && out_ready: clear out_valid, increment ops_done, go to IDLE.
  - in_valid is ignored in DONE. There is no same-cycle re-accept.
- mul_a and mul_b are 0 outside RUN. mul_p is ignored outside RUN.
- A and B are don't-care after the accept edge. Changes to them must not affect the in-flight result.
- ops_done wraps from 2^CNT_W-1 to 0.

## Timing
- Reset, applied in any state including mid-RUN or DONE:
  - Next edge: state=IDLE, acc=0, step=0, P=0, out_valid=0, ops_done=0.
  - The in-flight operation is discarded and produces no output.
- While rst is high: in_ready=0, busy=0, mul_a=0, mul_b=0.
- First cycle after rst deasserts: in_ready=1.
- Latency: accept at edge k; RUN occupies cycles k..k+3; out_valid is high after edge k+4.
  - ZERO_SKIP path: out_valid is high after edge k+1.
- Throughput: minimum 6 cycles per operation (accept, 4 RUN, 1 DONE, 1 IDLE) with out_ready held high.
- in_ready and busy are decoded from the state register only. There is no combinational path from in_valid or out_ready to any output.
- Core path: mul_a and mul_b are decoded from registers only. The core must settle within one cycle; mul_p -> acc is the single-cycle critical path.
- out_ready held low: P is stable for an unbounded time and ops_done does not change.

## Test plan
- Reset, then A=3, B=5, in_valid pulse; mul_p from a behavioural 2x2 model -> out_valid exactly 4 cycles after the accept edge with P=15; mul_a/mul_b sequence (3,1),(3,1),(0,1),(0,1); ops_done=1 after the handshake.
- A=15, B=15 -> P=225; acc never exceeds 8 bits. Exhaustive sweep of all 256 pairs -> P==A*B for every pair; ops_done=256 (0 when CNT_W=8).
- Hold out_ready=0 for 10 cycles after a 9x7 result -> P=63 and out_valid stable; in_ready=0 throughout; in_valid pulses in that window are not accepted.
- Assert rst in RUN step 2 of A=10, B=12 -> next cycle all outputs 0, no out_valid for that operation; the next operation 6x6 yields P=36.
- ZERO_SKIP=1 with A=0, B=9 -> out_valid after 1 cycle, P=0, mul_a/mul_b stay 0. ZERO_SKIP=0 with the same pair -> 4-cycle latency and P=0.
- Change A and B every cycle after the accept of 13x11 -> P=143; back-to-back stream with out_ready=1 -> one result per 6 cycles.
